// File: rtl/maxpool2x2_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : maxpool2x2_scheduler
// Description : Sequences a 2x2 / stride-2 signed max-pool over a feature map
//               held in an external single-port read memory. For each output
//               window it issues four reads (a, b, c, d), reduces them to their
//               signed maximum and writes the result to the output buffer in
//               raster order.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start               - begin a pass (sampled only when idle)
//               img_w, img_h        - input map dimensions (latched on start)
//               in_base, out_base   - map base addresses (latched on start)
//               rd_en/rd_addr       - memory read request
//               rd_data             - read data, valid one cycle after rd_en
//               wr_en/wr_addr/wr_data - pooled-result write port
//               busy                - pass in progress
//               done                - one-cycle end-of-pass pulse
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool2x2_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DIM_WIDTH-1:0]         img_w,
  input  logic [DIM_WIDTH-1:0]         img_h,
  input  logic [ADDR_WIDTH-1:0]        in_base,
  input  logic [ADDR_WIDTH-1:0]        out_base,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic signed [DATA_WIDTH-1:0] wr_data,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LAST  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                       r_state;
  logic [1:0]                   r_phase;      // which of a/b/c/d is on rd_addr
  logic [DIM_WIDTH-1:0]         r_col;        // output column of current window
  logic [DIM_WIDTH-1:0]         r_row;        // output row of current window
  logic [DIM_WIDTH-1:0]         r_col_last;   // OW-1
  logic [DIM_WIDTH-1:0]         r_row_last;   // OH-1
  logic [ADDR_WIDTH-1:0]        r_w;          // latched width, in address units
  logic [ADDR_WIDTH-1:0]        r_row_base;   // address of input row 2r, column 0
  logic [ADDR_WIDTH-1:0]        r_win_addr;   // address of pixel a of current window
  logic [ADDR_WIDTH-1:0]        r_out_ptr;    // out_base + k
  logic signed [DATA_WIDTH-1:0] r_a;
  logic signed [DATA_WIDTH-1:0] r_b;
  logic signed [DATA_WIDTH-1:0] r_c;

  logic                         r_rd_en;
  logic [ADDR_WIDTH-1:0]        r_rd_addr;
  logic                         r_wr_en;
  logic [ADDR_WIDTH-1:0]        r_wr_addr;
  logic signed [DATA_WIDTH-1:0] r_wr_data;
  logic                         r_busy;
  logic                         r_done;

  logic                         w_pass_nonempty;
  logic [ADDR_WIDTH-1:0]        w_img_w_addr;
  logic [DIM_WIDTH-1:0]         w_ow_m1;
  logic [DIM_WIDTH-1:0]         w_oh_m1;
  logic [ADDR_WIDTH-1:0]        w_next_row_base;
  logic [ADDR_WIDTH-1:0]        w_next_col_addr;
  logic signed [DATA_WIDTH-1:0] w_max_ab;
  logic signed [DATA_WIDTH-1:0] w_max_cd;
  logic signed [DATA_WIDTH-1:0] w_max;

  assign w_pass_nonempty = (img_w > DIM_WIDTH'(1)) && (img_h > DIM_WIDTH'(1));
  assign w_img_w_addr    = ADDR_WIDTH'(img_w);
  assign w_ow_m1         = (img_w >> 1) - DIM_WIDTH'(1);
  assign w_oh_m1         = (img_h >> 1) - DIM_WIDTH'(1);

  // Stride 2 in both directions: next window row starts two input rows down,
  // next window column starts two pixels right.
  assign w_next_row_base = r_row_base + (r_w << 1);
  assign w_next_col_addr = r_win_addr + ADDR_WIDTH'(2);

  // Pixel d is not stored: it is taken straight off rd_data in the LAST cycle
  // and folded into the result that is registered onto wr_data.
  assign w_max_ab = (r_a > r_b)     ? r_a : r_b;
  assign w_max_cd = (r_c > rd_data) ? r_c : rd_data;
  assign w_max    = (w_max_ab > w_max_cd) ? w_max_ab : w_max_cd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_phase    <= 2'd0;
      r_col      <= '0;
      r_row      <= '0;
      r_col_last <= '0;
      r_row_last <= '0;
      r_w        <= '0;
      r_row_base <= '0;
      r_win_addr <= '0;
      r_out_ptr  <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_w        <= w_img_w_addr;
            r_col_last <= w_ow_m1;
            r_row_last <= w_oh_m1;
            r_col      <= '0;
            r_row      <= '0;
            r_phase    <= 2'd0;
            r_row_base <= in_base;
            r_win_addr <= in_base;
            r_out_ptr  <= out_base;
            if (w_pass_nonempty) begin
              r_state   <= S_FETCH;
              r_busy    <= 1'b1;
              r_rd_en   <= 1'b1;
              r_rd_addr <= in_base;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        // rd_data lags rd_addr by one cycle, so phase p captures pixel p-1.
        S_FETCH: begin
          r_phase <= r_phase + 2'd1;
          case (r_phase)
            2'd0: r_rd_addr <= r_win_addr + ADDR_WIDTH'(1);
            2'd1: begin
              r_a       <= rd_data;
              r_rd_addr <= r_win_addr + r_w;
            end
            2'd2: begin
              r_b       <= rd_data;
              r_rd_addr <= r_win_addr + r_w + ADDR_WIDTH'(1);
            end
            default: begin
              r_c     <= rd_data;
              r_rd_en <= 1'b0;
              r_state <= S_LAST;
            end
          endcase
        end

        S_LAST: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_out_ptr;
          r_wr_data <= w_max;
          r_state   <= S_WRITE;
        end

        S_WRITE: begin
          r_out_ptr <= r_out_ptr + ADDR_WIDTH'(1);
          if ((r_col == r_col_last) && (r_row == r_row_last)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_FETCH;
            r_rd_en <= 1'b1;
            if (r_col == r_col_last) begin
              r_col      <= '0;
              r_row      <= r_row + DIM_WIDTH'(1);
              r_row_base <= w_next_row_base;
              r_win_addr <= w_next_row_base;
              r_rd_addr  <= w_next_row_base;
            end else begin
              r_col      <= r_col + DIM_WIDTH'(1);
              r_win_addr <= w_next_col_addr;
              r_rd_addr  <= w_next_col_addr;
            end
          end
        end

        // start is deliberately not sampled here.
        S_DONE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
`default_nettype wire
